// File: rtl/iobuf_cfg_sequencer_if.sv
// Configuration request channel between the command/register layer and the I/O buffer sequencer.
// The requester uses the master modport and the sequencer uses the slave modport.
interface iobuf_cfg_sequencer_if #(
  parameter int unsigned NPINS = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [NPINS-1:0] cfg_mask;
  logic [NPINS-1:0] cfg_oe;
  logic [NPINS-1:0] cfg_od;
  logic [NPINS-1:0] cfg_dir;

  modport master (
    output cfg_valid,
    output cfg_mask,
    output cfg_oe,
    output cfg_od,
    output cfg_dir,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_mask,
    input  cfg_oe,
    input  cfg_od,
    input  cfg_dir,
    output cfg_ready
  );
endinterface

// File: rtl/iobuf_cfg_sequencer.sv
// Break-before-make sequencer for the oe/od/dir controls of NPINS I/O buffers.
// Define IOBUF_SEQ_READBACK_EN to add the pin_din / rb_data / rb_valid readback path.
module iobuf_cfg_sequencer #(
  parameter int unsigned NPINS         = 8,
  parameter int unsigned DEAD_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  iobuf_cfg_sequencer_if.slave  cfg,
  output logic                  busy,
  output logic                  done,
  output logic [NPINS-1:0]      pin_oe,
  output logic [NPINS-1:0]      pin_od,
  output logic [NPINS-1:0]      pin_dir
`ifdef IOBUF_SEQ_READBACK_EN
  ,
  input  logic [NPINS-1:0]      pin_din,
  output logic [NPINS-1:0]      rb_data,
  output logic                  rb_valid
`endif
);

  localparam int unsigned CntMax = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  // DISABLE and APPLY each own one edge, so the wait states cover the remaining cycles.
  localparam logic [CntW-1:0] DeadLoad   = (DEAD_CYCLES > 1)   ? CntW'(DEAD_CYCLES - 2)   : '0;
  localparam logic [CntW-1:0] SettleLoad = (SETTLE_CYCLES > 1) ? CntW'(SETTLE_CYCLES - 2) : '0;

  typedef enum logic [2:0] {
    StIdle,
    StDisable,
    StDead,
    StApply,
    StSettle,
    StEnable
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [NPINS-1:0] mask_q, mask_d;
  logic [NPINS-1:0] req_oe_q, req_oe_d;
  logic [NPINS-1:0] req_od_q, req_od_d;
  logic [NPINS-1:0] req_dir_q, req_dir_d;
  logic [NPINS-1:0] pin_oe_q, pin_oe_d;
  logic [NPINS-1:0] pin_od_q, pin_od_d;
  logic [NPINS-1:0] pin_dir_q, pin_dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef IOBUF_SEQ_READBACK_EN
  logic [NPINS-1:0] rb_data_q, rb_data_d;
`endif

  assign cfg.cfg_ready = (state_q == StIdle) & ~rst;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    req_oe_d  = req_oe_q;
    req_od_d  = req_od_q;
    req_dir_d = req_dir_q;
    pin_oe_d  = pin_oe_q;
    pin_od_d  = pin_od_q;
    pin_dir_d = pin_dir_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef IOBUF_SEQ_READBACK_EN
    rb_data_d = rb_data_q;
`endif

    case (state_q)
      StIdle: begin
        if (cfg.cfg_valid) begin
          mask_d    = cfg.cfg_mask;
          req_oe_d  = cfg.cfg_oe;
          req_od_d  = cfg.cfg_od;
          req_dir_d = cfg.cfg_dir;
          // No masked dir/od change means no contention risk: skip straight to enable.
          if ((((cfg.cfg_dir ^ pin_dir_q) | (cfg.cfg_od ^ pin_od_q)) & cfg.cfg_mask) == '0) begin
            state_d = StEnable;
          end else begin
            state_d = StDisable;
          end
        end
      end
      StDisable: begin
        pin_oe_d = pin_oe_q & ~mask_q;
        busy_d   = 1'b1;
        if (DEAD_CYCLES > 1) begin
          state_d = StDead;
          cnt_d   = DeadLoad;
        end else begin
          state_d = StApply;
        end
      end
      StDead: begin
        if (cnt_q == '0) begin
          state_d = StApply;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StApply: begin
        pin_dir_d = (pin_dir_q & ~mask_q) | (req_dir_q & mask_q);
        pin_od_d  = (pin_od_q & ~mask_q) | (req_od_q & mask_q);
        if (SETTLE_CYCLES > 1) begin
          state_d = StSettle;
          cnt_d   = SettleLoad;
        end else begin
          state_d = StEnable;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StEnable;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StEnable: begin
        pin_oe_d = (pin_oe_q & ~mask_q) | (req_oe_q & mask_q);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
`ifdef IOBUF_SEQ_READBACK_EN
        // pin_dir_q already holds the new direction here; driven pins read back as 0.
        rb_data_d = pin_din & ~pin_dir_q;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mask_q    <= '0;
      req_oe_q  <= '0;
      req_od_q  <= '0;
      req_dir_q <= '0;
      pin_oe_q  <= '0;
      pin_od_q  <= '0;
      pin_dir_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef IOBUF_SEQ_READBACK_EN
      rb_data_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      req_oe_q  <= req_oe_d;
      req_od_q  <= req_od_d;
      req_dir_q <= req_dir_d;
      pin_oe_q  <= pin_oe_d;
      pin_od_q  <= pin_od_d;
      pin_dir_q <= pin_dir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef IOBUF_SEQ_READBACK_EN
      rb_data_q <= rb_data_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pin_oe  = pin_oe_q;
  assign pin_od  = pin_od_q;
  assign pin_dir = pin_dir_q;
`ifdef IOBUF_SEQ_READBACK_EN
  assign rb_data  = rb_data_q;
  assign rb_valid = done_q;
`endif

endmodule
